// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch port
// and the data-memory port. One access is granted at a time; the winner's
// request is latched and held on the RAM for MEM_LAT cycles, then a one-cycle
// ready pulse returns the captured read data.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate between if_req and d_req
// BUSY_I | fetch access driving the RAM, cnt counts RAM cycles
// BUSY_D | data access (load or store) driving the RAM
// RESP_I | if_ready pulse, if_rdata holds the fetched word
// RESP_D | d_ready pulse, d_rdata holds the loaded word (unchanged on store)
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STV_W-1:0]    starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                busy;
  logic                fetch_starved;

  // A waiting fetch wins the tie only once the data port has had its quota.
  assign fetch_starved = if_req && (starve_q == STV_SAT);

  // Arbitration, access sequencing and read-data capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_req && !fetch_starved) begin
          state_d  = BUSY_D;
          addr_d   = d_addr;
          we_d     = d_we;
          wdata_d  = d_wdata;
          cnt_d    = '0;
          if (!if_req)
            starve_d = '0;
          else if (starve_q != STV_SAT)
            starve_d = starve_q + 1'b1;
        end else if (if_req) begin
          state_d  = BUSY_I;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          cnt_d    = '0;
          starve_d = '0;
        end
      end
      BUSY_I: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          if_rdata_d = ram_rdata;
          state_d    = RESP_I;
        end
      end
      BUSY_D: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          if (!we_q)
            d_rdata_d = ram_rdata;
          state_d = RESP_D;
        end
      end
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // RAM controls decode straight from state so reset drops them without a clock.
  assign busy      = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign ram_en    = busy;
  assign ram_we    = (state_q == BUSY_D) && we_q;
  assign ram_addr  = busy ? addr_q : '0;
  assign ram_wdata = (state_q == BUSY_D) ? wdata_q : '0;

  assign if_ready  = (state_q == RESP_I);
  assign d_ready   = (state_q == RESP_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a word-array RAM model, per-port expected-data
// queues filled at request time from a reference memory, and a monitor that
// checks every ready pulse, every RAM burst and the fetch starvation bound.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MEM_LAT = 2;
  localparam int STARVE_MAX = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          stall_if;
  logic          stall_mem;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  // Fetch region 0x000-0x0FC is read-only; data region 0x100-0x3FC.
  bit [31:0] mem [256];
  bit [31:0] ref_mem [256];
  bit [31:0] d_last;
  bit [31:0] exp_if[$];
  bit [31:0] exp_d[$];
  logic [31:0] grant_log[$];
  int we_cycles;
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[9:2]] = ram_wdata;
      else ram_rdata <= mem[ram_addr[9:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] swap_addr, output int lat);
    int n = 0;
    bit done = 0;
    bit swapped = 0;
    if_req = 1'b1;
    if_addr = addr;
    exp_if.push_back(ref_mem[addr[9:2]]);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (if_ready) begin
        done = 1;
        chk("stall_if_at_ready", 32'(stall_if), 0);
      end else begin
        n++;
        chk("stall_if_wait", 32'(stall_if), 1);
        if (ram_en && ram_addr == addr && !swapped && swap_addr != addr) begin
          if_addr = swap_addr;
          swapped = 1;
        end
      end
    end
    chk("fetch_timeout", 32'(done), 1);
    lat = n;
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_data(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit done = 0;
    d_req = 1'b1;
    d_we = we;
    d_addr = addr;
    d_wdata = wdata;
    if (we) ref_mem[addr[9:2]] = wdata;
    else d_last = ref_mem[addr[9:2]];
    exp_d.push_back(d_last);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (d_ready) begin
        done = 1;
        chk("stall_mem_at_ready", 32'(stall_mem), 0);
      end else begin
        chk("stall_mem_wait", 32'(stall_mem), 1);
      end
    end
    chk("data_timeout", 32'(done), 1);
    @(posedge clk); #1;
    d_req = 1'b0;
    d_we = 1'b0;
  endtask

  // Monitor: scoreboard pops on ready, burst shape and starvation bound.
  initial begin
    bit prev_en = 0;
    bit prev_if = 0;
    bit is_data = 0;
    int run = 0;
    int starve_cnt = 0;
    logic [31:0] gaddr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 0; prev_if = 0; run = 0; starve_cnt = 0;
      end else begin
        if (if_ready) begin
          if (exp_if.size() == 0) chk("if_unexpected_ready", 32'(if_ready), 0);
          else chk("if_rdata", if_rdata, exp_if.pop_front());
        end
        if (d_ready) begin
          if (exp_d.size() == 0) chk("d_unexpected_ready", 32'(d_ready), 0);
          else chk("d_rdata", d_rdata, exp_d.pop_front());
        end
        if (ram_en) begin
          if (!prev_en) begin
            gaddr = ram_addr;
            run = 0;
            is_data = (ram_addr >= 32'h100);
            grant_log.push_back(ram_addr);
            if (is_data && prev_if) starve_cnt++;
            else starve_cnt = 0;
            chk("starve_bound", 32'(starve_cnt > STARVE_MAX), 0);
          end
          run++;
          chk("ram_addr_held", ram_addr, gaddr);
          chk("fetch_no_we", 32'(ram_we & ~is_data), 0);
          if (ram_we) we_cycles++;
        end else if (prev_en) begin
          chk("busy_len", 32'(run), 32'(MEM_LAT));
          chk("ready_after_busy", 32'(if_ready | d_ready), 1);
        end
        prev_en = ram_en;
        prev_if = if_req;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit pat [6];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    d_last = '0;
    we_cycles = 0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      mem[i] = ref_mem[i];
    end
    ref_mem['h40 >> 2] = 32'h8C220004; mem['h40 >> 2] = 32'h8C220004;
    ref_mem['h80 >> 2] = 32'h12345678; mem['h80 >> 2] = 32'h12345678;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_if_ready", 32'(if_ready), 0);
    chk("rst_d_ready", 32'(d_ready), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single fetch: latency and returned word
    do_fetch(32'h40, 32'h40, lat);
    chk("fetch_latency", 32'(lat), 32'(MEM_LAT + 1));
    chk("if_rdata_0x40", if_rdata, 32'h8C220004);

    // Store then load back
    we_cycles = 0;
    do_data(1'b1, 32'h100, 32'hDEADBEEF);
    chk("store_we_cycles", 32'(we_cycles), 32'(MEM_LAT));
    do_data(1'b0, 32'h100, 32'h0);
    chk("load_after_store", d_rdata, 32'hDEADBEEF);

    // Simultaneous requests: data first, then fetch
    grant_log.delete();
    fork
      do_fetch(32'h44, 32'h44, lat);
      do_data(1'b0, 32'h104, 32'h0);
    join
    chk("simul_grants", 32'(grant_log.size()), 2);
    if (grant_log.size() == 2) begin
      chk("simul_first", grant_log[0], 32'h104);
      chk("simul_second", grant_log[1], 32'h44);
    end

    // Continuous contention: D, D, I, D, D, I
    grant_log.delete();
    fork
      begin
        repeat (4) do_data(1'b0, 32'h100 + 4 * $urandom_range(0, 127), 32'h0);
      end
      begin
        int l;
        repeat (2) do_fetch(4 * $urandom_range(0, 63), 32'hFFFF_FFFF, l);
      end
    join
    chk("starve_grants", 32'(grant_log.size()), 6);
    if (grant_log.size() == 6)
      for (int i = 0; i < 6; i++)
        chk("starve_order", 32'(grant_log[i] >= 32'h100), 32'(pat[i]));

    // Fetch address changed mid-access is ignored
    do_fetch(32'h40, 32'h80, lat);
    chk("swap_if_rdata", if_rdata, 32'h8C220004);

    // Randomized concurrent traffic
    fork
      begin
        int l;
        for (int k = 0; k < 40; k++) begin
          automatic logic [31:0] a = 4 * $urandom_range(0, 63);
          do_fetch(a, a, l);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          do_data(1'($urandom_range(0, 1)), 32'h100 + 4 * $urandom_range(0, 127), $urandom);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
    join

    // Reset during a store
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3F0; d_wdata = $urandom;
    for (int i = 0; i < 20 && !ram_we; i++) @(negedge clk);
    chk("rst_test_we_seen", 32'(ram_we), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we_drop", 32'(ram_we), 0);
    chk("async_en_drop", 32'(ram_en), 0);
    d_req = 1'b0; d_we = 1'b0;
    d_last = '0;
    @(negedge clk);
    chk("no_ready_in_reset", 32'(d_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_ready_after_reset", 32'(d_ready), 0);
    chk("d_rdata_cleared", d_rdata, 0);
    @(posedge clk); #1;
    do_data(1'b0, 32'h100 + 4 * $urandom_range(0, 127), 32'h0);

    repeat (3) @(posedge clk);
    chk("sb_if_empty", 32'(exp_if.size()), 0);
    chk("sb_d_empty", 32'(exp_d.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the pipeline's instruction-fetch (IF) port and its data-memory (MEM-stage) port.
- Grants one access at a time and sequences a fixed-latency RAM access.
- Returns read data with a one-cycle ready pulse and produces per-port stall signals that freeze the pipeline while an access is pending.
- Sits between the pipeline top and the unified memory.

Parameters:
- ADDR_W, 32, address width of both ports and the RAM.
- DATA_W, 32, data width.
- MEM_LAT, 2, RAM access cycles (≥1); the address is held for MEM_LAT cycles and data is valid in the last of them.
- STARVE_MAX, 2, consecutive data grants allowed while a fetch waits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction, valid when if_ready.
- if_ready  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, valid when d_ready.
- d_ready  out  1  one-cycle completion pulse.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- stall_if  out  1  if_req & ~if_ready (combinational).
- stall_mem  out  1  d_req & ~d_ready (combinational).

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- Reset values (immediate on rst_n low, any state): state=IDLE, cnt=0, starve=0; if_rdata=0, d_rdata=0; if_ready=0, d_ready=0; ram_en=0, ram_we=0; ram_addr=0, ram_wdata=0.
- IDLE grant rules:
  - d_req only → BUSY_D.
  - if_req only → BUSY_I.
  - Both high → BUSY_D, unless starve==STARVE_MAX, then BUSY_I.
  - Neither → stay in IDLE.
- On grant, latch the port's addr, we and wdata into internal registers and clear cnt. Requester signals are not sampled again until the next IDLE.
- BUSY_x:
  - ram_en=1; ram_addr and ram_wdata come from the latched registers.
  - ram_we = latched we (BUSY_D only; always 0 in BUSY_I).
  - cnt increments each cycle.
  - When cnt==MEM_LAT-1: capture ram_rdata into if_rdata or d_rdata (reads only; stores leave d_rdata unchanged), then go to RESP_x.
- RESP_x: the matching *_ready=1 for exactly this cycle; ram_en=0; next state IDLE.
- Latency: req seen in IDLE at cycle t → BUSY cycles t+1..t+MEM_LAT → ready at t+MEM_LAT+1. Back-to-back accesses are separated by one IDLE cycle. Throughput is one access per MEM_LAT+2 cycles.
- Starvation counter:
  - Increments on each data grant made while if_req is high, saturating at STARVE_MAX.
  - Clears on any fetch grant.
  - Clears on a data grant made while if_req is low.
- Rdata registers hold their value between accesses.
- A requester that drops req mid-access does not abort it; the access completes and ready still pulses.
- Reset mid-write: ram_we drops asynchronously and the access is discarded; no ready pulse is issued.
- Request address/data changes while BUSY are ignored because the values are latched.

Test Plan:
- Reset (MEM_LAT=2): if_req=1, if_addr=0x40, RAM word 0x40=0x8C220004 → ram_en high for 2 cycles with ram_addr=0x40; if_ready pulses 3 cycles after grant; if_rdata=0x8C220004; stall_if high until then.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → ram_we high for 2 cycles; d_ready pulses once. A following load from 0x100 → d_rdata=0xDEADBEEF.
- Simultaneous if_req and d_req (addresses 0x44 / 0x104) → data is served first, then fetch. ram_addr sequence is 0x104, 0x104, then IDLE, then 0x44, 0x44.
- d_req held continuously with if_req also high (STARVE_MAX=2) → grant order D, D, I, D, D, I…; the fetch never waits more than 2 data accesses.
- rst_n pulsed low during BUSY_D with d_we=1 → ram_we and ram_en go to 0 immediately without a clock edge; no d_ready pulse; after release, state is IDLE and the next d_req is granted normally.
- if_addr changed from 0x40 to 0x80 mid-BUSY_I → ram_addr stays 0x40 and returned data is the 0x40 word.
